// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared 8n1 UART bit-timing constants and LFSR helpers.
// Used by uart_tx, uart_baud_lfsr and (later) the receiver.
package uart_tx_pkg;

  localparam int LFSR_W = 11;

  localparam logic [LFSR_W-1:0] SLOW_FULL = 11'h78c;
  localparam logic [LFSR_W-1:0] FAST_FULL = 11'h68e;

  localparam int SLOW_CYCLES = 1085;
  localparam int FAST_CYCLES = 31;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] l
  );
    return {l[9:0], l[10] ^ l[8]};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_full(input logic fast);
    return fast ? FAST_FULL : SLOW_FULL;
  endfunction

endpackage

// File: rtl/uart_baud_lfsr.sv
// uart_baud_lfsr: 11-bit LFSR bit timer; load selects FULL value by fast.
// Ports: clk, load, fast (in); tick (out, lfsr all ones = last bit cycle).
module uart_baud_lfsr
  import uart_tx_pkg::*;
(
  input  logic clk,
  input  logic load,
  input  logic fast,
  output logic tick
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (load) lfsr_d = lfsr_full(fast);
  end

  // Free-running when idle; the owner always loads before use.
  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  assign tick = &lfsr_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8n1 UART transmitter with one-entry holding register.
// Ports: clk, rst (sync, active-low), data/valid/ready, high_speed; tx, busy.
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  input  logic       high_speed,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_START,
    S_D0, S_D1, S_D2, S_D3,
    S_D4, S_D5, S_D6, S_D7,
    S_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       fast_q, fast_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       tick;
  logic       lfsr_load;
  logic       take;
  logic       accept;

  uart_baud_lfsr u_lfsr (
    .clk  (clk),
    .load (lfsr_load),
    .fast (fast_d),
    .tick (tick)
  );

  assign accept = valid & ~hold_full_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    fast_d    = fast_q;
    lfsr_load = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        take = hold_full_q;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_D0;
          lfsr_load = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          lfsr_load = 1'b1;
          if (hold_full_q) take = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          lfsr_load = 1'b1;
          if (state_q == S_D7) state_d = S_STOP;
          else state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
    // Holding register feeds the shifter: from IDLE or straight out of STOP.
    if (take) begin
      state_d   = S_START;
      shift_d   = hold_q;
      fast_d    = high_speed;
      lfsr_load = 1'b1;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (take) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_STOP:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      default: tx_d = shift_d[0];
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
    fast_q  <= fast_d;
  end

  assign ready = ~hold_full_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8n1 UART transmitter, the transmit-side counterpart of the UART receiver.
- Accepts bytes over a valid/ready handshake and serialises them onto `tx`: LSB first, one start bit (0), eight data bits, one stop bit (1).
- Bit timing uses an 11-bit LFSR rather than a binary counter. Default rate 115200 baud from 125 MHz; `high_speed` selects 4M baud for testing.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- SLOW_FULL, 11'h78c, LFSR load value giving a 1085-cycle bit period (115200 baud @ 125 MHz).
- FAST_FULL, 11'h68e, LFSR load value giving a 31-cycle bit period (4M baud @ 125 MHz).

Ports:
- clk  input  1  system clock, 125 MHz.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- data  input  8  byte to transmit.
- valid  input  1  `data` is valid.
- ready  output  1  holding register empty; a transfer occurs when `valid && ready` at a rising clk edge.
- tx  output  1  serial line, idle high, registered.
- high_speed  input  1  1 = FAST_FULL timing, 0 = SLOW_FULL; sampled only at frame start.
- busy  output  1  a frame is in progress (state != IDLE), registered.

Behaviour:
- Reset (rst low at a clk edge):
  - state = IDLE, tx = 1, ready = 1, busy = 0, holding register empty.
  - Data, shift and LFSR registers need no reset.
  - Reset mid-frame aborts immediately: tx = 1 from the next edge; any held byte is discarded.
- LFSR:
  - Recurrence: next = { lfsr[9:0], lfsr[10] ^ lfsr[8] }.
  - A bit ends on the cycle where &lfsr is true; the LFSR then reloads FULL.
  - Every bit, including start and stop, lasts exactly 1085 clocks (slow) or 31 clocks (fast).
  - The speed is latched into an internal `fast` flag when START is entered. Changes to `high_speed` mid-frame take effect at the next frame.
- States: IDLE, START, D0..D7, STOP.
  - IDLE: tx = 1. If the holding register is full, move it to the shifter, load the LFSR, latch `fast`, go to START.
  - START: tx = 0. On &lfsr go to D0.
  - Dn: tx = shifter[0]. On &lfsr shift right and go to D(n+1), with D7 going to STOP.
  - STOP: tx = 1. On &lfsr:
    - if the holding register is full, go directly to START (load shifter, reload LFSR, relatch `fast`);
    - otherwise go to IDLE.
- Handshake:
  - `ready` = holding register empty, registered.
  - Byte accepted at edge k → `ready` = 0 after edge k.
  - If state was IDLE: START is entered and the holding register is emptied at edge k+1. `tx` falls and `ready` rises after edge k+1 (2-edge latency from accept to start bit).
  - While a frame is in progress, one further byte may be accepted. `ready` stays 0 until that byte moves into the shifter at the end of STOP.
  - `valid` with `ready` = 0 has no effect; `data` must be held by the producer.
  - An accept and a shifter load at the same edge cannot occur, because `ready` is 0 whenever the holding register is full.
- `tx` is registered and glitch-free. It is driven combinationally from the next-state/shifter value into a flop.

Decomposition:
- Shared header (common.vh / uart definitions):
  - SLOW_FULL and FAST_FULL load values, also used by the receiver's full-bit timing;
  - the LFSR tap expression;
  - the 115200 / 4M cycle counts for benches.
- State encodings stay local.
- Natural sub-module: uart_baud_lfsr. It holds the 11-bit LFSR with load/reload and a `tick` (&lfsr) output, and is reusable by uart_rx.
- The FSM, holding register and shifter stay in uart_tx.

Test Plan:
- Reset: hold rst low 3 cycles with valid = 1 → tx = 1, ready = 1, busy = 0 throughout; no frame starts until rst goes high.
- Slow byte: send 0xA5, high_speed = 0 → tx low 2 edges after accept, then 0,1,0,1,0,0,1,0,1,1, each exactly 1085 cycles; busy high for 10850 cycles; then IDLE.
- Back-to-back fast: send 0x00 then 0xFF, high_speed = 1 → second byte accepted during frame 1; STOP of 0x00 is followed immediately by START with no idle cycle; total 620 cycles of tx activity.
- Backpressure: with the holding register full, a third byte 0x3C on valid sees ready = 0 until the end of frame 1's STOP; 0x3C is then accepted and sent third, intact.
- Mid-frame reset: assert rst during D3 of 0x5A → tx = 1, ready = 1 next edge; a subsequent byte 0x81 is sent correctly from a fresh START.
- Speed latch: toggle high_speed 0→1 during D2 → current frame keeps 1085-cycle bits; the next frame uses 31-cycle bits.
